// File: rtl/ssp_pkg.sv
// Shared SSP definitions used by both the transmit and receive FIFOs.
package ssp_pkg;

    localparam int unsigned SSP_DATA_WIDTH = 8;
    localparam int unsigned SSP_FIFO_DEPTH = 4;
    localparam int unsigned SSP_PTR_WIDTH  = 2;

    typedef logic [SSP_DATA_WIDTH-1:0] ssp_word_t;

endpackage

// File: rtl/ssp_tx_fifo_if.sv
// Push/pop handshake and head-word outputs of the SSP transmit FIFO.
interface ssp_tx_fifo_if
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SSP_DATA_WIDTH
);

    logic                  PSEL;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  NextWord;
    logic [DATA_WIDTH-1:0] TxData;
    logic                  TxDataValid;
    logic                  SSPTXINTR;

    modport master (
        output PSEL,
        output PWRITE,
        output PWDATA,
        output NextWord,
        input  TxData,
        input  TxDataValid,
        input  SSPTXINTR
    );

    modport slave (
        input  PSEL,
        input  PWRITE,
        input  PWDATA,
        input  NextWord,
        output TxData,
        output TxDataValid,
        output SSPTXINTR
    );

endinterface

// File: rtl/ssp_fifo_core.sv
// Circular-buffer FIFO core shared by the SSP transmit and receive FIFOs.
module ssp_fifo_core
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SSP_DATA_WIDTH,
    parameter int unsigned DEPTH      = SSP_FIFO_DEPTH,
    parameter int unsigned PTR_WIDTH  = SSP_PTR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [PTR_WIDTH:0]   CountFull = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PtrLast   = PTR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH:0]    r_count;

    logic [PTR_WIDTH-1:0]  w_wr_ptr_d;
    logic [PTR_WIDTH-1:0]  w_rd_ptr_d;
    logic [PTR_WIDTH:0]    w_count_d;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_acc;
    logic                  w_pop_acc;

    always_comb begin
        w_full     = (r_count == CountFull);
        w_empty    = (r_count == '0);
        w_pop_acc  = i_pop & ~w_empty;
        // A full FIFO still takes a push when the same edge frees a slot.
        w_push_acc = i_push & (~w_full | w_pop_acc);

        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_count_d  = r_count;

        if (w_push_acc) begin
            w_wr_ptr_d = (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_pop_acc) begin
            w_rd_ptr_d = (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
        end

        unique case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_count  <= w_count_d;
            if (w_push_acc) begin
                r_mem[r_wr_ptr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: APB write decode in front of the shared FIFO core.
module ssp_tx_fifo
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SSP_DATA_WIDTH,
    parameter int unsigned DEPTH      = SSP_FIFO_DEPTH,
    parameter int unsigned PTR_WIDTH  = SSP_PTR_WIDTH
) (
    input  logic          PCLK,
    input  logic          CLEAR_B,
    ssp_tx_fifo_if.slave  bus
);

    logic                  w_push_req;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;

    // PSEL without PWRITE is a read aimed at the receive FIFO.
    assign w_push_req = bus.PSEL & bus.PWRITE;

    ssp_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_core (
        .i_clk   (PCLK),
        .i_rst_n (CLEAR_B),
        .i_push  (w_push_req),
        .i_pop   (bus.NextWord),
        .i_wdata (bus.PWDATA),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.TxData      = w_empty ? '0 : w_head;
    assign bus.TxDataValid = ~w_empty;
    assign bus.SSPTXINTR   = w_full;

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Self-checking bench for ssp_tx_fifo with a queue-based reference model.
module tb_ssp_tx_fifo;
    import ssp_pkg::*;

    logic PCLK = 1'b0;
    logic CLEAR_B;

    ssp_tx_fifo_if #(.DATA_WIDTH(8)) bus ();

    ssp_tx_fifo dut (
        .PCLK    (PCLK),
        .CLEAR_B (CLEAR_B),
        .bus     (bus.slave)
    );

    always #20 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    logic [7:0] pop_exp;
    logic [7:0] pop_dut;
    logic       popped;

    function automatic logic [7:0] exp_data();
        return (sb.size() != 0) ? sb[0] : 8'h00;
    endfunction

    // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
    task automatic cyc(input logic psel, input logic pwrite, input logic [7:0] d, input logic nw);
        logic pop_ok;
        logic push_ok;
        bus.PSEL     = psel;
        bus.PWRITE   = pwrite;
        bus.PWDATA   = d;
        bus.NextWord = nw;
        pop_dut      = bus.TxData;
        @(posedge PCLK);
        popped = 1'b0;
        if (!CLEAR_B) begin
            sb.delete();
        end else begin
            pop_ok  = nw && (sb.size() > 0);
            push_ok = psel && pwrite && ((sb.size() < 4) || pop_ok);
            if (pop_ok) begin
                pop_exp = sb.pop_front();
                popped  = 1'b1;
            end
            if (push_ok) sb.push_back(d);
        end
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        CLEAR_B = 1'b0;
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        CLEAR_B = 1'b1;
        checks++;
        if (bus.TxData !== 8'h00) begin
            errors++; $display("FAIL reset_txdata: got %h want 00", bus.TxData);
        end
        checks++;
        if (bus.TxDataValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.TxDataValid);
        end
        checks++;
        if (bus.SSPTXINTR !== 1'b0) begin
            errors++; $display("FAIL reset_intr: got %b want 0", bus.SSPTXINTR);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.TxDataValid !== 1'b0) begin
            errors++; $display("FAIL reset_nothing_stored: valid %b want 0", bus.TxDataValid);
        end
    endtask

    task automatic test_single();
        cyc(1'b1, 1'b1, 8'hE7, 1'b0);
        checks++;
        if (bus.TxDataValid !== 1'b1 || bus.TxData !== 8'hE7) begin
            errors++;
            $display("FAIL single_push: got %b/%h want 1/e7", bus.TxDataValid, bus.TxData);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (pop_dut !== 8'hE7) begin
            errors++; $display("FAIL single_popword: got %h want e7", pop_dut);
        end
        checks++;
        if (bus.TxDataValid !== 1'b0 || bus.TxData !== 8'h00) begin
            errors++;
            $display("FAIL single_empty: got %b/%h want 0/00", bus.TxDataValid, bus.TxData);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] words [4] = '{8'hE7, 8'h3A, 8'h29, 8'hC5};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, words[i], 1'b0);
            checks++;
            if (bus.SSPTXINTR !== (i == 3)) begin
                errors++;
                $display("FAIL fill_intr[%0d]: got %b want %b", i, bus.SSPTXINTR, (i == 3));
            end
        end
        cyc(1'b1, 1'b1, 8'h5B, 1'b0);
        checks++;
        if (bus.SSPTXINTR !== 1'b1 || bus.TxData !== 8'hE7) begin
            errors++;
            $display("FAIL overflow_drop: got %b/%h want 1/e7", bus.SSPTXINTR, bus.TxData);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (pop_dut !== words[i]) begin
                errors++; $display("FAIL drain_word[%0d]: got %h want %h", i, pop_dut, words[i]);
            end
            checks++;
            if (bus.SSPTXINTR !== 1'b0 || bus.TxDataValid !== (i != 3)) begin
                errors++;
                $display("FAIL drain_flags[%0d]: got intr %b valid %b want 0/%b",
                         i, bus.SSPTXINTR, bus.TxDataValid, (i != 3));
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] fill [4] = '{8'h3A, 8'h29, 8'hC5, 8'h11};
        cyc(1'b1, 1'b1, 8'hE7, 1'b0);
        cyc(1'b1, 1'b1, 8'h3A, 1'b1);
        checks++;
        if (bus.TxData !== 8'h3A || bus.TxDataValid !== 1'b1) begin
            errors++;
            $display("FAIL simul_one: got %b/%h want 1/3a", bus.TxDataValid, bus.TxData);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.TxDataValid !== 1'b0) begin
            errors++; $display("FAIL simul_count1: valid %b want 0", bus.TxDataValid);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, fill[i], 1'b0);
        cyc(1'b1, 1'b1, 8'h5B, 1'b1);
        checks++;
        if (bus.SSPTXINTR !== 1'b1 || bus.TxData !== 8'h29) begin
            errors++;
            $display("FAIL simul_full: got %b/%h want 1/29", bus.SSPTXINTR, bus.TxData);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (!popped || pop_dut !== pop_exp) begin
                errors++;
                $display("FAIL simul_drain[%0d]: got %h want %h (popped %b)",
                         i, pop_dut, pop_exp, popped);
            end
        end
        checks++;
        if (pop_dut !== 8'h5B || bus.TxDataValid !== 1'b0) begin
            errors++;
            $display("FAIL simul_last: got %h/%b want 5b/0", pop_dut, bus.TxDataValid);
        end
    endtask

    task automatic test_underflow_wrap();
        logic [7:0] got [$];
        // {psel, pop, data}: pushes 01..06 interleaved with pops, crossing the pointer wrap
        logic [9:0] seq [12] = '{
            {2'b10, 8'h01}, {2'b10, 8'h02}, {2'b11, 8'h03}, {2'b01, 8'h00},
            {2'b10, 8'h04}, {2'b11, 8'h05}, {2'b10, 8'h06}, {2'b01, 8'h00},
            {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, 8'h00}};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (bus.TxDataValid !== 1'b0 || bus.TxData !== 8'h00) begin
                errors++;
                $display("FAIL underflow[%0d]: got %b/%h want 0/00", i, bus.TxDataValid, bus.TxData);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cyc(seq[i][9], seq[i][9], seq[i][7:0], seq[i][8]);
            if (popped) got.push_back(pop_dut);
            checks++;
            if (bus.TxData !== exp_data() || bus.TxDataValid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL wrap_state[%0d]: got %b/%h want %b/%h",
                         i, bus.TxDataValid, bus.TxData, (sb.size() != 0), exp_data());
            end
        end
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL wrap_count: got %0d pops want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], 8'(i + 1));
                end
            end
        end
        cyc(1'b1, 1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 1'b1, 8'hA2, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'hFF, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.TxDataValid !== 1'b1 || bus.TxData !== 8'hA2) begin
            errors++;
            $display("FAIL read_noop_1: got %b/%h want 1/a2", bus.TxDataValid, bus.TxData);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.TxDataValid !== 1'b0) begin
            errors++; $display("FAIL read_noop_2: valid %b want 0", bus.TxDataValid);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b1, 8'h10, 1'b0);
        cyc(1'b1, 1'b1, 8'h20, 1'b0);
        cyc(1'b1, 1'b1, 8'h30, 1'b0);
        CLEAR_B = 1'b0;
        cyc(1'b1, 1'b1, 8'h77, 1'b0);
        CLEAR_B = 1'b1;
        checks++;
        if (bus.TxDataValid !== 1'b0 || bus.TxData !== 8'h00 || bus.SSPTXINTR !== 1'b0) begin
            errors++;
            $display("FAIL midreset_empty: got %b/%h/%b want 0/00/0",
                     bus.TxDataValid, bus.TxData, bus.SSPTXINTR);
        end
        cyc(1'b1, 1'b1, 8'h88, 1'b0);
        checks++;
        if (bus.TxDataValid !== 1'b1 || bus.TxData !== 8'h88) begin
            errors++;
            $display("FAIL midreset_push: got %b/%h want 1/88", bus.TxDataValid, bus.TxData);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.TxDataValid !== 1'b0 || pop_dut !== 8'h88) begin
            errors++;
            $display("FAIL midreset_count1: got %b/%h want 0/88", bus.TxDataValid, pop_dut);
        end
    endtask

    initial begin
        CLEAR_B      = 1'b1;
        bus.PSEL     = 1'b0;
        bus.PWRITE   = 1'b0;
        bus.PWDATA   = '0;
        bus.NextWord = 1'b0;
        @(negedge PCLK);
        test_reset();
        test_single();
        test_fill_overflow();
        test_simultaneous();
        test_underflow_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssp_tx_fifo.md
Name: ssp_tx_fifo

Overview:
Transmit-side FIFO of the SSP block. It is the counterpart of the receive FIFO.
- The APB side pushes bytes: PSEL & PWRITE with PWDATA.
- The SSP transmit logic pops bytes: NextWord.
- It presents the head word on TxData with a valid flag, and raises SSPTXINTR while the FIFO is full.
- It sits between the APB slave interface and the SSP transmit shift logic.

Parameters:
- DATA_WIDTH, 8, width of each FIFO word.
- DEPTH, 4, number of entries.
- PTR_WIDTH, 2, log2(DEPTH); read/write pointer width. The occupancy counter is PTR_WIDTH+1 bits.

Ports:
- PCLK  in  1  system clock; all state changes on its rising edge.
- CLEAR_B  in  1  reset, synchronous, active-low.
- PSEL  in  1  APB select for the transmit FIFO.
- PWRITE  in  1  APB write strobe; a push requires PSEL=1 and PWRITE=1.
- PWDATA  in  DATA_WIDTH  byte to push.
- NextWord  in  1  transmit logic consumed the head word; one pop per cycle held high.
- TxData  out  DATA_WIDTH  head-of-FIFO word; 0 when empty.
- TxDataValid  out  1  FIFO non-empty.
- SSPTXINTR  out  1  FIFO full (count == DEPTH).

Behaviour:
- Reset:
  - CLEAR_B sampled low at a PCLK edge clears rd_ptr, wr_ptr, count and all memory words to 0.
  - From the next cycle: TxData=0, TxDataValid=0, SSPTXINTR=0.
  - Reset has priority over any push or pop at the same edge; a reset mid-operation discards all contents.
- Push request: push_req = PSEL & PWRITE.
  - Accepted if count < DEPTH, or if count == DEPTH and a pop is accepted at the same edge.
  - Accepted push: mem[wr_ptr] <= PWDATA, wr_ptr increments modulo DEPTH.
  - A push to a full FIFO with no concurrent pop is silently dropped; no state change.
- Pop request: pop_req = NextWord.
  - Accepted only if count > 0; rd_ptr increments modulo DEPTH.
  - A pop on empty is ignored, with no pointer or count change.
  - A push into an empty FIFO is never bypassed to a same-cycle pop: pop is rejected, push is accepted.
- Held requests: a request held high for N cycles performs N operations, each subject to the rules above. No edge detection.
- PSEL=1 with PWRITE=0 has no effect on this block (read path belongs to the receive FIFO).
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. Count never exceeds DEPTH and never underflows.
- Latency:
  - A word pushed at edge N appears on TxData and TxDataValid after edge N (one-cycle latency) when the FIFO was empty.
  - After a pop at edge N, TxData shows the next entry after edge N, or 0 if empty.
- Outputs:
  - TxData = (count != 0) ? mem[rd_ptr] : 0.
  - TxDataValid = (count != 0).
  - SSPTXINTR = (count == DEPTH).
  - All are decoded from registered state only, with no combinational path from inputs.
- Wrap-around: pointers wrap DEPTH-1 -> 0; ordering is strictly first-in first-out across wraps.
- State: no FSM beyond the pointer/count registers; the count register is the single source of full/empty.

Decomposition:
- Shared package ssp_pkg holds:
  - SSP_DATA_WIDTH = 8
  - SSP_FIFO_DEPTH = 4
  - SSP_PTR_WIDTH = 2
- The receive FIFO uses the same package.
- One sub-module is natural: ssp_fifo_core. It contains memory, pointers, count and push/pop acceptance, with full/empty outputs, and is reusable by the receive FIFO.
- ssp_tx_fifo wraps it with the APB push decode and output gating.

Test Plan (PCLK period 40 ns):
1. Reset: CLEAR_B=0 for 2 edges, with PSEL=1, PWRITE=1, PWDATA=8'hAA held -> TxData=00, TxDataValid=0, SSPTXINTR=0; nothing stored.
2. Single word: push E7 for one cycle -> next cycle TxDataValid=1, TxData=E7. Then NextWord for one cycle -> TxDataValid=0, TxData=00.
3. Fill and overflow:
   - Push E7, 3A, 29, C5 on consecutive cycles -> SSPTXINTR=1 after the 4th edge.
   - Push 5B -> dropped.
   - Hold NextWord 4 cycles -> TxData E7, 3A, 29, C5 in order; SSPTXINTR=0 after the first pop; TxDataValid=0 after the 4th pop.
4. Simultaneous operations:
   - Holding only E7, push 3A with NextWord in the same cycle -> TxData=3A, TxDataValid=1, count 1.
   - When full with 3A, 29, C5, 11, push 5B plus pop together -> SSPTXINTR stays 1, TxData=29. Subsequent pops yield 29, C5, 11, 5B.
5. Underflow and wrap:
   - NextWord held 3 cycles while empty -> no change.
   - Then push 6 words 01..06 interleaved with pops -> output order 01..06, no corruption across pointer wrap.
   - PSEL=1 with PWRITE=0 for 3 cycles -> count unchanged.
6. Reset mid-operation: with 3 words stored, assert CLEAR_B=0 for one edge together with push 77 -> empty, TxDataValid=0. Then push 88 -> TxData=88, count 1.
